// File: rtl/bnn_alu_pkg.sv
// Shared constants and helpers for the bnn bit-serial accumulate ALU.
package alu_pkg;

  localparam int ALU_W_DEFAULT = 12;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Signed range limit of a w-bit two's-complement value: max when want_max, else min.
  function automatic longint signed_lim(input int w, input logic want_max);
    longint mag;
    mag = longint'(1) << (w - 1);
    return want_max ? (mag - 1) : -mag;
  endfunction

endpackage

// File: rtl/bnn_alu_if.sv
// Operand/result bundle between the XNOR fetch stage and the accumulate ALU.
interface bnn_alu_if #(
  parameter int alu_width = alu_pkg::ALU_W_DEFAULT
);
  logic                 alu_in_valid;
  logic                 alu_in_a_lsb;
  logic                 alu_in_x;
  logic                 alu_in_w;
  logic [alu_width-1:0] alu_in_b;
  logic [alu_width-1:0] alu_out;
  logic                 alu_out_valid;
  logic                 alu_ovf;

  modport master (
    output alu_in_valid, alu_in_a_lsb, alu_in_x, alu_in_w, alu_in_b,
    input  alu_out, alu_out_valid, alu_ovf
  );

  modport slave (
    input  alu_in_valid, alu_in_a_lsb, alu_in_x, alu_in_w, alu_in_b,
    output alu_out, alu_out_valid, alu_ovf
  );
endinterface

// File: rtl/bnn_alu_addsub.sv
// Combinational add/subtract of a single activation bit with signed overflow detect.
// Saturation on overflow is built in when ALU_SAT_EN is defined; otherwise the result wraps.
module bnn_addsub
  import alu_pkg::*;
#(
  parameter int alu_width = ALU_W_DEFAULT
) (
  input  logic                 a_lsb,
  input  logic                 op,
  input  logic [alu_width-1:0] b,
  output logic [alu_width-1:0] res,
  output logic                 ovf
);

  logic [alu_width:0] b_ext;
  logic [alu_width:0] a_ext;
  logic [alu_width:0] sum_ext;

  assign b_ext   = {b[alu_width-1], b};
  assign a_ext   = {{alu_width{1'b0}}, a_lsb};
  assign sum_ext = (op == OP_SUB) ? (b_ext - a_ext) : (b_ext + a_ext);

  // The extra bit disagrees with the width-bit sign only when the true result left the range.
  assign ovf = sum_ext[alu_width] ^ sum_ext[alu_width-1];

`ifdef ALU_SAT_EN
  localparam logic [alu_width-1:0] SAT_MAX = alu_width'(signed_lim(alu_width, 1'b1));
  localparam logic [alu_width-1:0] SAT_MIN = alu_width'(signed_lim(alu_width, 1'b0));

  always_comb begin
    res = sum_ext[alu_width-1:0];
    if (ovf) begin
      res = (op == OP_SUB) ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign res = sum_ext[alu_width-1:0];
`endif

endmodule

// File: rtl/bnn_alu.sv
// Bit-serial accumulate ALU: adds or subtracts one activation bit to a partial sum, registered.
// Optional saturation on overflow is selected by the ALU_SAT_EN macro (see bnn_addsub).
module bnn_alu
  import alu_pkg::*;
#(
  parameter int alu_width = ALU_W_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  bnn_alu_if.slave  bus
);

  logic                 op;
  logic [alu_width-1:0] res;
  logic                 ovf;

  // Product of the two +/-1 bits is -1 exactly when they differ.
  assign op = (bus.alu_in_x ^ bus.alu_in_w) ? OP_SUB : OP_ADD;

  bnn_addsub #(
    .alu_width (alu_width)
  ) u_addsub (
    .a_lsb (bus.alu_in_a_lsb),
    .op    (op),
    .b     (bus.alu_in_b),
    .res   (res),
    .ovf   (ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.alu_out       <= '0;
      bus.alu_out_valid <= 1'b0;
      bus.alu_ovf       <= 1'b0;
    end else begin
      bus.alu_out_valid <= bus.alu_in_valid;
      if (bus.alu_in_valid) begin
        bus.alu_out <= res;
        bus.alu_ovf <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_bnn_alu.sv
// Self-checking bench for bnn_alu: directed steps plus randomized traffic against a +/-1 arithmetic model.
module tb_bnn_alu;
  localparam int W    = 12;
  localparam int SMAX = 2047;
  localparam int SMIN = -2048;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [W-1:0] exp_out;
  logic         exp_valid;
  logic         exp_ovf;

  bnn_alu_if #(.alu_width(W)) alu_if ();

  bnn_alu #(.alu_width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (alu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: signed integer arithmetic on +/-1 products, then range handling.
  task automatic model(input logic a, input logic x, input logic w, input logic [W-1:0] b,
                       output logic [W-1:0] r_bits, output logic o);
    int bs;
    int sgn;
    int r;
    bs  = int'($signed(b));
    sgn = (x == w) ? 1 : -1;
    r   = bs + sgn * int'(a);
    o   = (r > SMAX) || (r < SMIN);
`ifdef ALU_SAT_EN
    if (r > SMAX) r = SMAX;
    if (r < SMIN) r = SMIN;
`endif
    r_bits = r[W-1:0];
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_out"},   32'(alu_if.alu_out),       32'(exp_out));
    check({tag, "_valid"}, 32'(alu_if.alu_out_valid), 32'(exp_valid));
    check({tag, "_ovf"},   32'(alu_if.alu_ovf),       32'(exp_ovf));
  endtask

  task automatic step(input string tag, input logic v, input logic a, input logic x,
                      input logic w, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         o;
    @(negedge clk);
    alu_if.alu_in_valid = v;
    alu_if.alu_in_a_lsb = a;
    alu_if.alu_in_x     = x;
    alu_if.alu_in_w     = w;
    alu_if.alu_in_b     = b;
    model(a, x, w, b, r, o);
    @(posedge clk);
    #1;
    exp_valid = v;
    if (v) begin
      exp_out = r;
      exp_ovf = o;
    end
    check_outs(tag);
  endtask

  task automatic model_reset();
    exp_out   = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rb;
    n_checks = 0;
    n_fail   = 0;
    model_reset();

    // Reset held while random valid traffic is presented.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      alu_if.alu_in_valid = 1'b1;
      alu_if.alu_in_a_lsb = 1'($urandom);
      alu_if.alu_in_x     = 1'($urandom);
      alu_if.alu_in_w     = 1'($urandom);
      alu_if.alu_in_b     = W'($urandom);
    end
    #1;
    check_outs("rst_hold");
    @(negedge clk);
    alu_if.alu_in_valid = 1'b0;
    rst = 1'b1;
    step("rst_rel", 1'b0, 1'b1, 1'b1, 1'b1, 12'd5);

    // Add path, back to back.
    step("add0", 1'b1, 1'b1, 1'b1, 1'b1, 12'd0);
    step("add1", 1'b1, 1'b1, 1'b1, 1'b1, 12'd1);
    step("add2", 1'b1, 1'b1, 1'b1, 1'b1, 12'd2);
    step("add3", 1'b1, 1'b1, 1'b1, 1'b1, 12'd3);
    step("add_a0", 1'b1, 1'b0, 1'b1, 1'b1, 12'd2);
    step("add_x0w0", 1'b1, 1'b1, 1'b0, 1'b0, 12'd9);

    // Subtract path.
    step("sub2", 1'b1, 1'b1, 1'b1, 1'b0, 12'd2);
    step("sub_a0", 1'b1, 1'b0, 1'b1, 1'b0, 12'd2);
    step("sub_m1", 1'b1, 1'b1, 1'b1, 1'b0, 12'd4095);
    step("sub_0", 1'b1, 1'b1, 1'b1, 1'b0, 12'd0);
    check("sub_0_lit", 32'(alu_if.alu_out), 32'd4095);
    step("sub_x0w1", 1'b1, 1'b1, 1'b0, 1'b1, 12'd7);

    // Wrap and overflow boundaries.
    step("add_4095", 1'b1, 1'b1, 1'b1, 1'b1, 12'd4095);
    check("add_4095_lit", 32'(alu_if.alu_out), 32'd0);
    step("add_max", 1'b1, 1'b1, 1'b1, 1'b1, 12'd2047);
`ifdef ALU_SAT_EN
    check("add_max_lit", 32'(alu_if.alu_out), 32'd2047);
`else
    check("add_max_lit", 32'(alu_if.alu_out), 32'd2048);
`endif
    check("add_max_ovf", 32'(alu_if.alu_ovf), 32'd1);
    step("sub_min", 1'b1, 1'b1, 1'b0, 1'b1, 12'd2048);
`ifdef ALU_SAT_EN
    check("sub_min_lit", 32'(alu_if.alu_out), 32'd2048);
`else
    check("sub_min_lit", 32'(alu_if.alu_out), 32'd2047);
`endif
    check("sub_min_ovf", 32'(alu_if.alu_ovf), 32'd1);
    step("add_max_a0", 1'b1, 1'b0, 1'b1, 1'b1, 12'd2047);
    step("sub_min_a0", 1'b1, 1'b0, 1'b1, 1'b0, 12'd2048);

    // Valid gating: outputs hold, valid drops.
    step("hold_pre", 1'b1, 1'b1, 1'b1, 1'b1, 12'd100);
    step("hold1", 1'b0, 1'b1, 1'b1, 1'b0, 12'd500);
    step("hold2", 1'b0, 1'b0, 1'b0, 1'b1, 12'd2047);
    step("hold_post", 1'b1, 1'b1, 1'b1, 1'b0, 12'd2048);

    // Async reset between edges with a valid operation in flight.
    @(negedge clk);
    alu_if.alu_in_valid = 1'b1;
    alu_if.alu_in_a_lsb = 1'b1;
    alu_if.alu_in_x     = 1'b1;
    alu_if.alu_in_w     = 1'b1;
    alu_if.alu_in_b     = 12'd300;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_outs("async_rst");
    @(posedge clk);
    #1;
    check_outs("async_rst_edge");
    @(negedge clk);
    alu_if.alu_in_valid = 1'b0;
    rst = 1'b1;
    step("async_rel", 1'b0, 1'b1, 1'b1, 1'b1, 12'd1);

    // Randomized traffic, biased toward the range boundaries.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0:       rb = 12'd2047;
        1:       rb = 12'd2048;
        2:       rb = 12'd4095;
        default: rb = W'($urandom);
      endcase
      step("rand", ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom), rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_alu.md
Name: bnn_alu

Overview:
- Bit-serial accumulate ALU for the binarized neural-network (nna) datapath.
- Each valid cycle it adds or subtracts one activation bit (alu_in_a_lsb) to/from a 12-bit two's-complement partial sum (alu_in_b).
- The sign of the step is the binary product of input bit x and weight bit w, interpreted as ±1.
- Sits between the XNOR/weight fetch stage and the partial-sum register file; the result is registered (1-cycle latency).

Parameters:
- alu_width, 12, width of partial-sum input/output in bits (two's complement, minimum 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- alu_in_valid  input  1  operands valid this cycle.
- alu_in_a_lsb  input  1  activation bit to accumulate (magnitude 0 or 1).
- alu_in_x  input  1  binary input bit (0 means -1, 1 means +1).
- alu_in_w  input  1  binary weight bit (0 means -1, 1 means +1).
- alu_in_b  input  alu_width  incoming partial sum, signed.
- alu_out  output  alu_width  registered result, signed.
- alu_out_valid  output  1  alu_out holds a result computed from a valid input.
- alu_ovf  output  1  signed overflow occurred on the registered result.

Behaviour:
- Operation select: sub = alu_in_x XOR alu_in_w. Matching bits (product +1) select add; mismatching bits (product -1) select subtract.
- Add result: alu_in_b + alu_in_a_lsb. Subtract result: alu_in_b - alu_in_a_lsb. The a bit is zero-extended to alu_width.
- Arithmetic is computed in alu_width+1 bits. Signed overflow is detected when:
  - add: b = max positive (2^(w-1)-1) and a = 1;
  - subtract: b = min negative (-2^(w-1)) and a = 1.
- Default (no saturation): result wraps modulo 2^alu_width, e.g. 4095 + 1 = 0. alu_ovf is still reported.
- Registers update on the rising edge of clk only when alu_in_valid = 1. When alu_in_valid = 0, alu_out and alu_ovf hold their values and alu_out_valid goes to 0 on the next edge.
- Latency: exactly 1 cycle from valid input to alu_out_valid = 1. Back-to-back valid inputs give one result per cycle.
- Reset (rst = 0, asynchronous): alu_out = 0, alu_out_valid = 0, alu_ovf = 0, taking effect immediately regardless of clk. Outputs are released on the first rising edge after rst returns to 1.
- Reset mid-operation discards the in-flight result; no partial state survives reset.
- alu_in_a_lsb = 0: result equals alu_in_b in both modes, and alu_ovf = 0.
- No internal state other than the output registers; there is no accumulation across cycles inside the block.

Optional Feature:
- Macro ALU_SAT_EN.
- Defined: on signed overflow the result saturates. Add clamps to 2^(alu_width-1)-1 (2047 at default width); subtract clamps to -2^(alu_width-1) (2048 as raw bits). alu_ovf = 1 in that cycle.
- Not defined: the result wraps (two's-complement modulo). alu_ovf still flags overflow.

Decomposition:
- Package alu_pkg holds:
  - localparam ALU_W_DEFAULT = 12;
  - op encoding constants OP_ADD = 1'b0, OP_SUB = 1'b1;
  - a function returning the signed max/min values for a given width.
- One sub-module is natural: bnn_addsub, the combinational add/sub with overflow detect and optional saturation.
- The top level holds the valid/output registers and reset logic.

Test Plan:
- Reset: hold rst = 0 with random inputs, then release -> alu_out = 0, alu_out_valid = 0, alu_ovf = 0 until the first valid input.
- Add path: x = 1, w = 1, a = 1, b = 0, 1, 2, 3 on consecutive cycles -> alu_out = 1, 2, 3, 4, each one cycle later with alu_out_valid = 1. With a = 0, b = 2 -> 2.
- Subtract path: x = 1, w = 0, a = 1, b = 2 -> 1. a = 0, b = 2 -> 2. a = 1, b = -1 (4095) -> 4094. a = 1, b = 0 -> 4095 (-1), alu_ovf = 0.
- Wrap/overflow without ALU_SAT_EN:
  - add a = 1, b = 4095 -> 0 with alu_ovf = 0;
  - add a = 1, b = 2047 -> 2048 with alu_ovf = 1;
  - sub a = 1, b = 2048 -> 2047 with alu_ovf = 1.
- With ALU_SAT_EN: add a = 1, b = 2047 -> 2047 with alu_ovf = 1; sub a = 1, b = 2048 -> 2048 (-2048) with alu_ovf = 1.
- Valid gating and async reset: drop alu_in_valid for 2 cycles -> alu_out holds and alu_out_valid = 0. Assert rst between clock edges -> outputs clear immediately.
